// File: rtl/alu_ctrl_unit.sv
// Instruction sequencer driving a clocked alu: fetch/decode/exec/writeback over a synchronous ROM.
// Optional: define CTRL_ILLEGAL_TRAP_EN to halt with err=1 on illegal opcodes (default: execute as NOP).
module alu_ctrl_unit #(
    parameter int N     = 12,
    parameter int PC_W  = 8,
    parameter int INS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PC_W-1:0]  ins_addr,
    input  logic [INS_W-1:0] ins_data,
    output logic [2:0]       alu_op,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic [1:0]       wr_sel,
    output logic             wr_en,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    if (INS_W != 16 || N < 1) begin : g_bad_cfg
        $error("alu_ctrl_unit: INS_W must be 16 and N positive");
    end

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [14:6]     ir;
    logic            zflag;
    logic [1:0]      sel_a_q, sel_b_q, wr_sel_q;
    logic [3:0]      dec_op;
    logic [PC_W-1:0] dec_target;

    assign dec_op     = ins_data[15:12];
    assign dec_target = ins_data[PC_W-1:0];
    assign ins_addr   = pc;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic err_q, err_n;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Only the opcode low bits and register fields of ir are consumed after DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            zflag    <= 1'b0;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            wr_sel_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (state == DECODE) begin
                ir <= ins_data[14:6];
            end
            if (state == EXEC) begin
                sel_a_q <= ir[9:8];
                sel_b_q <= ir[7:6];
            end
            if (state == WB) begin
                wr_sel_q <= ir[11:10];
                zflag    <= z;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            err_q <= err_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
`ifdef CTRL_ILLEGAL_TRAP_EN
        err_n   = err_q;
`endif
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_n    = '0;
                    state_n = FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    err_n   = 1'b0;
`endif
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                case (dec_op)
                    4'h1, 4'h2, 4'h3, 4'h4: state_n = EXEC;
                    4'h0: begin
                        pc_n    = pc + PC_W'(1);
                        state_n = FETCH;
                    end
                    4'h8: begin
                        pc_n    = dec_target;
                        state_n = FETCH;
                    end
                    4'h9: begin
                        pc_n    = zflag ? dec_target : pc + PC_W'(1);
                        state_n = FETCH;
                    end
                    4'hF: state_n = HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_n = HALT;
                        err_n   = 1'b1;
`else
                        pc_n    = pc + PC_W'(1);
                        state_n = FETCH;
`endif
                    end
                endcase
            end
            EXEC: state_n = WB;
            WB: begin
                pc_n    = pc + PC_W'(1);
                state_n = FETCH;
            end
            default: state_n = IDLE;
        endcase
    end

    // Selects come live from ir in their active state and otherwise show the last issued value.
    always_comb begin
        alu_op = '0;
        sel_a  = sel_a_q;
        sel_b  = sel_b_q;
        wr_sel = wr_sel_q;
        wr_en  = 1'b0;
        busy   = (state != IDLE) && (state != HALT);
        done   = (state == HALT);
        case (state)
            EXEC: begin
                alu_op = ir[14:12];
                sel_a  = ir[9:8];
                sel_b  = ir[7:6];
            end
            WB: begin
                wr_en  = 1'b1;
                wr_sel = ir[11:10];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Bench for alu_ctrl_unit: instruction-level program interpreter produces an expected per-cycle timeline.
module tb_alu_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        z = 1'b0;
    logic [7:0]  ins_addr;
    logic [15:0] ins_data = '0;
    logic [2:0]  alu_op;
    logic [1:0]  sel_a, sel_b, wr_sel;
    logic        wr_en, busy, done, err;

    alu_ctrl_unit #(.N(12), .PC_W(8), .INS_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ins_addr(ins_addr), .ins_data(ins_data),
        .alu_op(alu_op), .sel_a(sel_a), .sel_b(sel_b), .wr_sel(wr_sel), .wr_en(wr_en),
        .z(z), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk_addr;
        int addr;
        int op;
        int sa;
        int sb;
        bit we;
        int ws;
        bit bsy;
        bit dn;
        bit er;
    } rec_t;

    int   checks = 0;
    int   failures = 0;
    int   zval = 0;
    int   m_sa = 0, m_sb = 0, m_zf = 0;
    rec_t exp_q[$];
    int   fetch_log[$];
    logic [15:0] rom [256];

    always @(posedge clk) ins_data <= rom[ins_addr];

    // ALU stand-in: z is the programmed value only in the cycle after an operation.
    always @(posedge clk) z <= (alu_op != 3'd0) ? zval[0] : ~zval[0];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        rec_t r;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("busy", busy, r.bsy);
            chk("done", done, r.dn);
            chk("err", err, r.er);
            chk("alu_op", alu_op, r.op);
            chk("sel_a", sel_a, r.sa);
            chk("sel_b", sel_b, r.sb);
            chk("wr_en", wr_en, r.we);
            if (r.we) chk("wr_sel", wr_sel, r.ws);
            if (r.chk_addr) chk("ins_addr", ins_addr, r.addr);
            if (r.chk_addr && r.bsy) fetch_log.push_back(int'(ins_addr));
        end
    end

    task automatic push(input bit ca, input int addr, input int op, input bit we, input int ws,
                        input bit bsy, input bit dn, input bit er);
        rec_t r;
        r.chk_addr = ca; r.addr = addr; r.op = op; r.sa = m_sa; r.sb = m_sb;
        r.we = we; r.ws = ws; r.bsy = bsy; r.dn = dn; r.er = er;
        exp_q.push_back(r);
    endtask

    task automatic push_halt(input int pc, input bit er);
        for (int i = 0; i < 3; i++) push(1'b1, pc, 0, 1'b0, 0, 1'b0, 1'b1, er);
    endtask

    // Interpret the program from pc=0 and emit one expected record per clock.
    task automatic gen(input int max_cycles);
        int pc = 0;
        int cyc = 0;
        int op, tgt;
        logic [15:0] ins;
        while (cyc < max_cycles) begin
            ins = rom[pc];
            op  = int'(ins[15:12]);
            tgt = int'(ins[7:0]);
            push(1'b1, pc, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
            push(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
            cyc += 2;
            if (op >= 1 && op <= 4) begin
                m_sa = int'(ins[9:8]);
                m_sb = int'(ins[7:6]);
                push(1'b0, 0, op, 1'b0, 0, 1'b1, 1'b0, 1'b0);
                push(1'b0, 0, 0, 1'b1, int'(ins[11:10]), 1'b1, 1'b0, 1'b0);
                m_zf = zval;
                pc = (pc + 1) % 256;
                cyc += 2;
            end else if (op == 0) begin
                pc = (pc + 1) % 256;
            end else if (op == 8) begin
                pc = tgt;
            end else if (op == 9) begin
                pc = (m_zf != 0) ? tgt : (pc + 1) % 256;
            end else if (op == 15) begin
                push_halt(pc, 1'b0);
                return;
            end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                push_halt(pc, 1'b1);
                return;
`else
                pc = (pc + 1) % 256;
`endif
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        fetch_log.delete();
        m_sa = 0; m_sb = 0; m_zf = 0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        fetch_log.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic check_fetch(input string name, input int n, input int a0, input int a1,
                               input int a2, input int a3);
        int ev[4];
        ev[0] = a0; ev[1] = a1; ev[2] = a2; ev[3] = a3;
        chk({name, "_count"}, fetch_log.size(), n);
        for (int i = 0; i < n && i < fetch_log.size(); i++)
            chk($sformatf("%s[%0d]", name, i), fetch_log[i], ev[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_rom();
        do_reset();
        @(negedge clk);
        chk("rst_ins_addr", ins_addr, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_wr_sel", wr_sel, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // ADD d1,a0,b2 ; HALT
        clear_rom();
        rom[0] = 16'h1480;
        rom[1] = 16'hF000;
        pulse_start();
        gen(50);
        repeat (3) @(negedge clk);
        chk("add_exec_alu_op", alu_op, 1);
        chk("add_exec_sel_a", sel_a, 0);
        chk("add_exec_sel_b", sel_b, 2);
        @(negedge clk);
        chk("add_wb_wr_en", wr_en, 1);
        chk("add_wb_wr_sel", wr_sel, 1);
        repeat (2) @(negedge clk);
        chk("add_done_early", done, 0);
        @(negedge clk);
        chk("add_done", done, 1);
        chk("add_final_addr", ins_addr, 1);
        wait_drain();
        check_fetch("add_fetch", 2, 0, 1, 0, 0);

        // SUB d0,a1,a1 ; JMPZ chain, taken with z=1
        clear_rom();
        rom[0] = 16'h2140;
        rom[1] = 16'h9005;
        rom[2] = 16'h9006;
        rom[3] = 16'hF000;
        rom[5] = 16'h9007;
        rom[7] = 16'hF000;
        do_reset();
        zval = 1;
        pulse_start();
        gen(50);
        wait_drain();
        check_fetch("jmpz_z1", 4, 0, 1, 5, 7);
        chk("jmpz_z1_done", done, 1);

        do_reset();
        zval = 0;
        pulse_start();
        gen(50);
        wait_drain();
        check_fetch("jmpz_z0", 4, 0, 1, 2, 3);
        chk("jmpz_z0_done", done, 1);

        // JMP 255 ; INC at 255 wraps pc to 0; start held high must be ignored while busy
        clear_rom();
        rom[0]   = 16'h80FF;
        rom[255] = 16'h4E00;
        do_reset();
        fetch_log.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        gen(12);
        wait_drain();
        start = 1'b0;
        check_fetch("wrap", 4, 0, 255, 0, 255);

        // Reset held two cycles from the middle of EXEC
        clear_rom();
        rom[0] = 16'h1480;
        rom[1] = 16'hF000;
        do_reset();
        pulse_start();
        repeat (3) @(negedge clk);
        chk("mid_exec_alu_op", alu_op, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_sel_b", sel_b, 0);
        chk("mid_rst_wr_sel", wr_sel, 0);
        chk("mid_rst_ins_addr", ins_addr, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_en", wr_en, 0);
        chk("post_rst_busy", busy, 0);
        m_sa = 0; m_sb = 0; m_zf = 0;

        // Illegal opcode 0xC at address 0
        clear_rom();
        rom[0] = 16'hC000;
        rom[1] = 16'hF000;
        do_reset();
        pulse_start();
        gen(50);
        wait_drain();
        chk("illegal_done", done, 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_fetch("illegal_fetch", 1, 0, 0, 0, 0);
        chk("illegal_err", err, 1);
        chk("illegal_addr", ins_addr, 0);
`else
        check_fetch("illegal_fetch", 2, 0, 1, 0, 0);
        chk("illegal_err", err, 0);
        chk("illegal_addr", ins_addr, 1);
`endif
        rom[0] = 16'hF000;
        pulse_start();
        gen(50);
        wait_drain();
        chk("restart_err", err, 0);
        chk("restart_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
